// File: rtl/cim_accum.sv
// Compute-in-memory accumulator: buffers PE tiles in a small FIFO and adds each
// head tile elementwise to the memory beat carrying the same address.
module cim_accum #(
  parameter int TILE  = 6,
  parameter int DW    = 12,
  parameter int AW    = 8,
  parameter int MEM_W = 512,
  parameter int DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [TILE*TILE*DW-1:0]   PE_tile_i,
  input  logic [AW-1:0]             PE_addr_i,
  input  logic                      PE_valid_i,
  output logic                      PE_ready_o,
  input  logic [MEM_W-1:0]          memory_data_i,
  input  logic [AW-1:0]             memory_addr_i,
  input  logic                      memory_valid_i,
  output logic                      memory_ready_o,
  input  logic                      sat_en_i,
  output logic [MEM_W-1:0]          result_o,
  output logic [AW-1:0]             result_addr_o,
  output logic                      result_valid_o,
  input  logic                      result_ready_i,
  output logic                      err_o,
  input  logic                      err_clr_i,
  output logic [15:0]               tile_cnt_o
);

  localparam int N  = TILE * TILE;
  localparam int TW = N * DW;
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  if (TW > MEM_W) begin : g_bad_width
    $error("cim_accum: TILE*TILE*DW exceeds MEM_W");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("cim_accum: DEPTH must be a power of two >= 2");
  end

  logic [TW-1:0] tile_mem_q [DEPTH];
  logic [AW-1:0] addr_mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;

  logic [TW-1:0] result_q;
  logic [AW-1:0] result_addr_q;
  logic          result_valid_q;
  logic          err_q, err_d;
  logic [15:0]   tile_cnt_q;

  logic          full, empty, out_free, push, fire, pop;
  logic [TW-1:0] head_tile, sum_tile;
  logic [AW-1:0] head_addr;
  logic          unused_mem_bits;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign head_tile = tile_mem_q[rd_ptr_q];
  assign head_addr = addr_mem_q[rd_ptr_q];
  assign out_free  = !result_valid_q || result_ready_i;

  // Ready is forced during reset so the interface looks empty before the first edge.
  assign PE_ready_o     = !full || rst_i;
  assign memory_ready_o = !empty && out_free && !rst_i;

  assign push = PE_valid_i && PE_ready_o && !rst_i;
  assign fire = memory_valid_i && memory_ready_o;
  assign pop  = fire && (memory_addr_i == head_addr);

  assign unused_mem_bits = ^memory_data_i;

  always_comb begin
    sum_tile = '0;
    for (int unsigned k = 0; k < N; k++) begin
      logic [DW-1:0] ea, eb;
      logic [DW:0]   s;
      ea = head_tile[k*DW +: DW];
      eb = memory_data_i[k*DW +: DW];
      s  = {ea[DW-1], ea} + {eb[DW-1], eb};
      // Overflow iff the extra sign bit disagrees with the result sign bit.
      if (sat_en_i && (s[DW] != s[DW-1]))
        sum_tile[k*DW +: DW] = s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      else
        sum_tile[k*DW +: DW] = s[DW-1:0];
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + 1'b1;
    else if (!push && pop)
      count_d = count_q - 1'b1;
  end

  always_comb begin
    err_d = err_q;
    if (err_clr_i)
      err_d = 1'b0;
    else if (fire && !pop)
      err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      tile_mem_q[wr_ptr_q] <= PE_tile_i;
      addr_mem_q[wr_ptr_q] <= PE_addr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      result_q       <= '0;
      result_addr_q  <= '0;
      result_valid_q <= 1'b0;
      err_q          <= 1'b0;
      tile_cnt_q     <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (pop) begin
        result_q       <= sum_tile;
        result_addr_q  <= head_addr;
        result_valid_q <= 1'b1;
      end else if (result_ready_i) begin
        result_valid_q <= 1'b0;
      end
      err_q <= err_d;
      if (result_valid_q && result_ready_i) tile_cnt_q <= tile_cnt_q + 16'd1;
    end
  end

  assign result_o       = MEM_W'(result_q);
  assign result_addr_o  = result_addr_q;
  assign result_valid_o = result_valid_q;
  assign err_o          = err_q;
  assign tile_cnt_o     = tile_cnt_q;

endmodule

// File: tb/tb_cim_accum.sv
// Self-checking bench for cim_accum: constant vectors, directed corner sequences,
// and random traffic against a queue-based transaction model.
module tb_cim_accum;
  localparam int TILE = 6, DW = 12, AW = 8, MEM_W = 512, DEPTH = 4;
  localparam int N = TILE * TILE, TW = N * DW;
  localparam int MAXV = (1 << (DW - 1)) - 1, MINV = -(1 << (DW - 1));

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_i;
  logic [TW-1:0]    PE_tile_i;
  logic [AW-1:0]    PE_addr_i;
  logic             PE_valid_i, PE_ready_o;
  logic [MEM_W-1:0] memory_data_i;
  logic [AW-1:0]    memory_addr_i;
  logic             memory_valid_i, memory_ready_o;
  logic             sat_en_i;
  logic [MEM_W-1:0] result_o;
  logic [AW-1:0]    result_addr_o;
  logic             result_valid_o, result_ready_i;
  logic             err_o, err_clr_i;
  logic [15:0]      tile_cnt_o;

  cim_accum #(.TILE(TILE), .DW(DW), .AW(AW), .MEM_W(MEM_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .PE_tile_i(PE_tile_i), .PE_addr_i(PE_addr_i), .PE_valid_i(PE_valid_i), .PE_ready_o(PE_ready_o),
    .memory_data_i(memory_data_i), .memory_addr_i(memory_addr_i),
    .memory_valid_i(memory_valid_i), .memory_ready_o(memory_ready_o),
    .sat_en_i(sat_en_i),
    .result_o(result_o), .result_addr_o(result_addr_o),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .err_o(err_o), .err_clr_i(err_clr_i), .tile_cnt_o(tile_cnt_o)
  );

  int total = 0, bad = 0;

  typedef struct { logic [TW-1:0] tile; logic [AW-1:0] addr; } ent_t;
  ent_t             q[$];
  bit               m_valid = 1'b0;
  logic [MEM_W-1:0] m_res   = '0;
  logic [AW-1:0]    m_addr  = '0;
  bit               m_err   = 1'b0;
  logic [15:0]      m_cnt   = '0;

  typedef struct { int a; int b; bit sat; int exp; } vec_t;
  vec_t vt[8];

  task automatic chk(input string name, input logic [MEM_W-1:0] act, input logic [MEM_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [MEM_W-1:0] tile_sum(input logic [TW-1:0] t, input logic [MEM_W-1:0] m, input bit sat);
    logic [MEM_W-1:0] r;
    logic [DW-1:0] ea, eb;
    int a, b, s;
    r = '0;
    for (int k = 0; k < N; k++) begin
      ea = t[k*DW +: DW];
      eb = m[k*DW +: DW];
      a = $signed(ea);
      b = $signed(eb);
      s = a + b;
      if (sat) begin
        if (s > MAXV) s = MAXV;
        if (s < MINV) s = MINV;
      end else begin
        s = s & ((1 << DW) - 1);
        if (s > MAXV) s = s - (1 << DW);
      end
      r[k*DW +: DW] = s[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic [TW-1:0] fill(input int v);
    logic [TW-1:0] r;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = v[DW-1:0];
    return r;
  endfunction

  function automatic logic [MEM_W-1:0] rnd_wide();
    logic [MEM_W-1:0] r;
    for (int i = 0; i < MEM_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_step();
    bit out_free, mem_rdy, push, fire, match;
    ent_t e;
    if (rst_i) begin
      q.delete();
      m_valid = 1'b0; m_res = '0; m_addr = '0; m_err = 1'b0; m_cnt = '0;
      return;
    end
    out_free = !m_valid || result_ready_i;
    mem_rdy  = (q.size() > 0) && out_free;
    push     = PE_valid_i && (q.size() < DEPTH);
    fire     = memory_valid_i && mem_rdy;
    match    = fire && (memory_addr_i == q[0].addr);
    if (m_valid && result_ready_i) m_cnt++;
    if (err_clr_i) m_err = 1'b0;
    else if (fire && !match) m_err = 1'b1;
    if (match) begin
      m_res  = tile_sum(q[0].tile, memory_data_i, sat_en_i);
      m_addr = q[0].addr;
      m_valid = 1'b1;
      void'(q.pop_front());
    end else if (result_ready_i) begin
      m_valid = 1'b0;
    end
    if (push) begin
      e.tile = PE_tile_i;
      e.addr = PE_addr_i;
      q.push_back(e);
    end
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic cyc();
    #1;
    chk("PE_ready", PE_ready_o, rst_i || (q.size() < DEPTH));
    chk("memory_ready", memory_ready_o, !rst_i && (q.size() > 0) && (!m_valid || result_ready_i));
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("result_valid", result_valid_o, m_valid);
    chk("result_data", result_o, m_res);
    chk("result_addr", result_addr_o, m_addr);
    chk("err", err_o, m_err);
    chk("tile_cnt", tile_cnt_o, m_cnt);
  endtask

  task automatic idle();
    rst_i = 1'b0; PE_valid_i = 1'b0; memory_valid_i = 1'b0;
    err_clr_i = 1'b0; result_ready_i = 1'b1; sat_en_i = 1'b0;
  endtask

  task automatic do_reset();
    idle(); rst_i = 1'b1; cyc(); rst_i = 1'b0;
  endtask

  task automatic push_tile(input logic [TW-1:0] t, input logic [AW-1:0] a);
    PE_valid_i = 1'b1; PE_tile_i = t; PE_addr_i = a; cyc(); PE_valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 4 * DEPTH && q.size() > 0; n++) begin
      memory_valid_i = 1'b1; memory_addr_i = q[0].addr; memory_data_i = rnd_wide();
      cyc();
    end
    memory_valid_i = 1'b0;
    cyc();
    chk("drain_empty", memory_ready_o, 1'b0);
  endtask

  initial begin
    vt[0] = '{100, 23, 1'b0, 123};
    vt[1] = '{100, 23, 1'b1, 123};
    vt[2] = '{2000, 100, 1'b1, 2047};
    vt[3] = '{2000, 100, 1'b0, -1996};
    vt[4] = '{-2048, -1, 1'b1, -2048};
    vt[5] = '{-2048, -1, 1'b0, 2047};
    vt[6] = '{2047, 2047, 1'b0, -2};
    vt[7] = '{-1000, -500, 1'b1, -1500};

    PE_tile_i = '0; PE_addr_i = '0; memory_data_i = '0; memory_addr_i = '0;
    idle();
    @(negedge clk);
    do_reset();
    chk("reset_valid", result_valid_o, 1'b0);
    chk("reset_pe_ready", PE_ready_o, 1'b1);
    chk("reset_mem_ready", memory_ready_o, 1'b0);
    chk("reset_cnt", tile_cnt_o, 16'd0);

    // elementwise add table, one tile per vector
    for (int i = 0; i < 8; i++) begin
      push_tile(fill(vt[i].a), AW'(5 + i));
      memory_valid_i = 1'b1; memory_addr_i = AW'(5 + i);
      memory_data_i = MEM_W'(fill(vt[i].b)); sat_en_i = vt[i].sat;
      cyc();
      memory_valid_i = 1'b0;
      chk("vec_valid", result_valid_o, 1'b1);
      chk("vec_sum", result_o, MEM_W'(fill(vt[i].exp)));
      chk("vec_addr", result_addr_o, AW'(5 + i));
    end
    cyc();

    // fill FIFO, fifth tile held until a pop, no bypass on the pop cycle
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_tile(rnd_wide(), AW'(8'h10 + i));
    chk("full_not_ready", PE_ready_o, 1'b0);
    PE_valid_i = 1'b1; PE_tile_i = rnd_wide(); PE_addr_i = 8'h14;
    cyc();
    chk("full_held", PE_ready_o, 1'b0);
    memory_valid_i = 1'b1; memory_addr_i = 8'h10; memory_data_i = rnd_wide();
    #1 chk("no_bypass", PE_ready_o, 1'b0);
    cyc();
    chk("ready_after_pop", PE_ready_o, 1'b1);
    memory_addr_i = 8'h11;
    cyc();
    PE_valid_i = 1'b0;
    drain();

    // address mismatch, then match, then clear; clear beats a simultaneous mismatch
    do_reset();
    push_tile(fill(7), 8'h03);
    memory_valid_i = 1'b1; memory_addr_i = 8'h04; memory_data_i = MEM_W'(fill(1));
    cyc();
    chk("mm_err", err_o, 1'b1);
    chk("mm_no_result", result_valid_o, 1'b0);
    memory_addr_i = 8'h03;
    cyc();
    chk("mm_result", result_valid_o, 1'b1);
    chk("mm_sum", result_o, MEM_W'(fill(8)));
    memory_valid_i = 1'b0; err_clr_i = 1'b1;
    cyc();
    chk("err_cleared", err_o, 1'b0);
    push_tile(fill(1), 8'h03);
    memory_valid_i = 1'b1; memory_addr_i = 8'h09;
    cyc();
    chk("clr_priority", err_o, 1'b0);
    err_clr_i = 1'b0;
    drain();

    // backpressure then a back-to-back stream of four results
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_tile(rnd_wide(), AW'(8'h20 + i));
    result_ready_i = 1'b0;
    memory_valid_i = 1'b1; memory_addr_i = 8'h20; memory_data_i = rnd_wide();
    cyc();
    memory_addr_i = 8'h21;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_mem_ready", memory_ready_o, 1'b0);
      chk("bp_valid", result_valid_o, 1'b1);
      chk("bp_addr", result_addr_o, 8'h20);
    end
    result_ready_i = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      memory_addr_i = AW'(8'h20 + i); memory_data_i = rnd_wide();
      cyc();
      chk("stream_valid", result_valid_o, 1'b1);
    end
    memory_valid_i = 1'b0;
    cyc();
    chk("stream_cnt", tile_cnt_o, 16'd4);

    // reset with two tiles buffered and a result pending
    do_reset();
    for (int i = 0; i < 3; i++) push_tile(rnd_wide(), AW'(8'h30 + i));
    result_ready_i = 1'b0;
    memory_valid_i = 1'b1; memory_addr_i = 8'h30; memory_data_i = rnd_wide();
    cyc();
    err_clr_i = 1'b0; memory_addr_i = 8'h31; rst_i = 1'b1;
    cyc();
    chk("rst_valid", result_valid_o, 1'b0);
    chk("rst_data", result_o, '0);
    chk("rst_addr", result_addr_o, '0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_cnt", tile_cnt_o, 16'd0);
    rst_i = 1'b0; result_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("rst_no_beat", memory_ready_o, 1'b0);
      chk("rst_pe_ready", PE_ready_o, 1'b1);
    end

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst_i          = ($urandom_range(0, 299) == 0);
      PE_valid_i     = ($urandom_range(0, 1) == 1);
      PE_tile_i      = rnd_wide();
      PE_addr_i      = AW'($urandom_range(0, 3));
      memory_valid_i = ($urandom_range(0, 2) != 0);
      memory_addr_i  = (q.size() > 0 && $urandom_range(0, 3) != 0) ? q[0].addr : AW'($urandom_range(0, 3));
      memory_data_i  = rnd_wide();
      sat_en_i       = ($urandom_range(0, 1) == 1);
      result_ready_i = ($urandom_range(0, 3) != 0);
      err_clr_i      = ($urandom_range(0, 9) == 0);
      cyc();
    end
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cim_accum.md
CIM_ACCUM -- requirements
Module: cim_accum

Interface
REQ-001 Parameter TILE, default 6, tile edge length; a tile holds TILE*TILE elements.
REQ-002 Parameter DW, default 12, signed element width in bits.
REQ-003 Parameter AW, default 8, tile address width.
REQ-004 Parameter MEM_W, default 512, memory word width; TILE*TILE*DW <= MEM_W (elaboration error otherwise).
REQ-005 Parameter DEPTH, default 4, PE tile buffer depth in entries (power of two, >= 2).
REQ-006 clk_i  in  1  single clock; all state updates on rising edge.
REQ-007 rst_i  in  1  synchronous, active-high reset.
REQ-008 PE_tile_i  in  TILE*TILE*DW  flat tile; element k = row*TILE+col at bits [k*DW +: DW].
REQ-009 PE_addr_i  in  AW  tile address; PE_valid_i  in  1; PE_ready_o  out  1.
REQ-010 memory_data_i  in  MEM_W  element k at bits [k*DW +: DW], bits above TILE*TILE*DW ignored.
REQ-011 memory_addr_i  in  AW; memory_valid_i  in  1; memory_ready_o  out  1.
REQ-012 sat_en_i  in  1  1 = saturating add, 0 = wrap-around add; sampled on the pop cycle.
REQ-013 result_o  out  MEM_W; result_addr_o  out  AW; result_valid_o  out  1; result_ready_i  in  1.
REQ-014 err_o  out  1  sticky address-mismatch flag; err_clr_i  in  1  clears err_o.
REQ-015 tile_cnt_o  out  16  count of results accepted downstream.

Function
REQ-016 PE tiles enter a DEPTH-entry FIFO (tile + address); push when PE_valid_i && PE_ready_o.
REQ-017 PE_ready_o = FIFO not full; no same-cycle bypass when full, even if a pop occurs.
REQ-018 Output stage is one register; "out_free" = !result_valid_o || result_ready_i.
REQ-019 memory_ready_o = FIFO not empty && out_free.
REQ-020 Memory beat fires when memory_valid_i && memory_ready_o.
REQ-021 Fire with memory_addr_i == FIFO-head address: pop head, load output register with elementwise sum, result_addr_o = head address, result_valid_o = 1 next cycle.
REQ-022 Fire with address mismatch: memory beat consumed and discarded, FIFO head kept, err_o set next cycle, output register unchanged.
REQ-023 Sum per element: DW-bit signed operands; wrap mode keeps low DW bits of the DW+1-bit sum.
REQ-024 Saturate mode clamps to [-2^(DW-1), 2^(DW-1)-1]; DW=12 gives [-2048, 2047].
REQ-025 result_o bits above TILE*TILE*DW are zero.
REQ-026 Latency: matching fire in cycle N -> result_valid_o high in cycle N+1.
REQ-027 result_o/result_addr_o hold stable while result_valid_o && !result_ready_i.
REQ-028 result_valid_o clears after accept unless a new fire occurs in the same cycle (back-to-back, one result per cycle).
REQ-029 Simultaneous push and pop: both happen; occupancy unchanged.
REQ-030 FIFO pointers wrap modulo DEPTH; occupancy counter range 0..DEPTH.
REQ-031 tile_cnt_o increments on result_valid_o && result_ready_i; wraps 0xFFFF -> 0.
REQ-032 err_clr_i has priority over a same-cycle mismatch set (err_o = 0).

Reset
REQ-033 While rst_i high at a clock edge: FIFO emptied, result_valid_o = 0, result_o = 0, result_addr_o = 0, err_o = 0, tile_cnt_o = 0.
REQ-034 Reset mid-operation drops buffered tiles and the pending result; no beat is accepted that cycle.
REQ-035 During and after reset, PE_ready_o = 1 and memory_ready_o = 0 (FIFO empty).

Verification
REQ-036 Single tile addr 0x05, all elements 100, memory addr 0x05 all elements 23 -> one cycle later result_valid_o = 1, every element 123, addr 0x05.
REQ-037 Elements 2000 + 100, sat_en_i = 1 -> 2047; sat_en_i = 0 -> -1996; -2048 + -1 saturates to -2048.
REQ-038 Push DEPTH+1 tiles, no memory beats -> PE_ready_o low after DEPTH pushes; fifth tile held until a pop.
REQ-039 Head addr 0x03, memory beat addr 0x04 -> err_o = 1, no result, head kept; next beat addr 0x03 -> result; err_clr_i -> err_o = 0.
REQ-040 result_ready_i low 3 cycles with a result pending -> result_o stable, memory_ready_o low; release -> stream of 4 matched tiles at one per cycle, tile_cnt_o = 4.
REQ-041 rst_i asserted with 2 tiles buffered and result pending -> next cycle all outputs at reset values, subsequent memory beats not accepted.
